// File: rtl/ctrl_pipe.sv
// Control-word shift pipe with per-stage flush, global hold and a drain FSM.
// Optional bubble counter is built only when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe #(
    parameter int unsigned CW     = 21,
    parameter int unsigned STAGES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            id_ctrl,
    input  logic                     id_valid,
    input  logic                     nop_req,
    input  logic                     hold,
    input  logic [STAGES-1:0]        flush,
    input  logic                     drain,
    input  logic                     cnt_clr,
    output logic [STAGES*CW-1:0]     stage_ctrl,
    output logic [STAGES-1:0]        stage_valid,
    output logic                     drained,
    output logic [15:0]              bubble_cnt
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t                state;
    logic                  entry_suppr;
    logic [CW-1:0]         entry_ctrl;
    logic                  entry_valid;
    logic [STAGES*CW-1:0]  nxt_ctrl;
    logic [STAGES-1:0]     nxt_valid;

    // Ctrl is masked by id_valid so an invalid slot never carries a stale word.
    always_comb begin
        entry_suppr = nop_req || (state != RUN);
        entry_valid = id_valid && !entry_suppr;
        entry_ctrl  = entry_valid ? id_ctrl : '0;
    end

    // Per-stage next value: flush beats hold beats advance.
    always_comb begin
        nxt_ctrl  = stage_ctrl;
        nxt_valid = stage_valid;
        if (flush[0]) begin
            nxt_ctrl[0 +: CW] = '0;
            nxt_valid[0]      = 1'b0;
        end else if (!hold) begin
            nxt_ctrl[0 +: CW] = entry_ctrl;
            nxt_valid[0]      = entry_valid;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (flush[k]) begin
                nxt_ctrl[k*CW +: CW] = '0;
                nxt_valid[k]         = 1'b0;
            end else if (!hold) begin
                nxt_ctrl[k*CW +: CW] = stage_ctrl[(k-1)*CW +: CW];
                nxt_valid[k]         = stage_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_ctrl  <= '0;
            stage_valid <= '0;
        end else begin
            stage_ctrl  <= nxt_ctrl;
            stage_valid <= nxt_valid;
        end
    end

    // Drain FSM; hold freezes it except for the DRAIN->RUN abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (!hold && drain) state <= DRAIN;
                end
                DRAIN: begin
                    if (!drain)                           state <= RUN;
                    else if (!hold && (nxt_valid == '0)) state <= IDLE;
                end
                IDLE: begin
                    if (!hold && !drain) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign drained = (state == IDLE);

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] bubble_q;
    logic             bubble_hit;

    assign bubble_hit = !hold && !flush[0] && id_valid && entry_suppr;

    // Saturating bubble counter; clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_q <= '0;
        end else if (cnt_clr) begin
            bubble_q <= '0;
        end else if (bubble_hit && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = bubble_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign bubble_cnt     = CNT_W'(0);
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed-vector bench for ctrl_pipe at CW=21, STAGES=3.
// Expected bubble counts follow CTRL_PIPE_PERF_EN so either build can be checked.
module tb_ctrl_pipe;

    localparam int unsigned CW     = 21;
    localparam int unsigned STAGES = 3;
`ifdef CTRL_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [CW-1:0]        id_ctrl;
    logic                 id_valid;
    logic                 nop_req;
    logic                 hold;
    logic [STAGES-1:0]    flush;
    logic                 drain;
    logic                 cnt_clr;
    logic [STAGES*CW-1:0] stage_ctrl;
    logic [STAGES-1:0]    stage_valid;
    logic                 drained;
    logic [15:0]          bubble_cnt;

    int total;
    int bad;

    ctrl_pipe #(.CW(CW), .STAGES(STAGES)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_ctrl     (id_ctrl),
        .id_valid    (id_valid),
        .nop_req     (nop_req),
        .hold        (hold),
        .flush       (flush),
        .drain       (drain),
        .cnt_clr     (cnt_clr),
        .stage_ctrl  (stage_ctrl),
        .stage_valid (stage_valid),
        .drained     (drained),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] sc(input int k);
        return stage_ctrl[k*CW +: CW];
    endfunction

    function automatic logic [15:0] exp_bub(input int n);
        return PERF ? 16'(n) : 16'h0000;
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        id_ctrl  = '0;
        id_valid = 1'b0;
        nop_req  = 1'b0;
        hold     = 1'b0;
        flush    = '0;
        drain    = 1'b0;
        cnt_clr  = 1'b0;

        // Reset state
        tick();
        check("rst_valid", 64'(stage_valid), 64'h0);
        check("rst_ctrl", 64'(stage_ctrl), 64'h0);
        check("rst_drained", 64'(drained), 64'h0);
        check("rst_bub", 64'(bubble_cnt), 64'h0);
        reset = 1'b1;

        // Single word walks through the three stages
        id_ctrl  = 21'h1ABCDE;
        id_valid = 1'b1;
        tick();
        check("flow_s0", 64'(sc(0)), 64'h1ABCDE);
        check("flow_v1", 64'(stage_valid), 64'b001);
        id_ctrl  = '0;
        id_valid = 1'b0;
        tick();
        check("flow_s1", 64'(sc(1)), 64'h1ABCDE);
        check("flow_v2", 64'(stage_valid), 64'b010);
        check("flow_s0_empty", 64'(sc(0)), 64'h0);
        tick();
        check("flow_s2", 64'(sc(2)), 64'h1ABCDE);
        check("flow_v3", 64'(stage_valid), 64'b100);
        tick();
        check("flow_gone", 64'(stage_valid), 64'b000);

        // Two bubbles
        id_ctrl  = 21'h00007;
        id_valid = 1'b1;
        nop_req  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bub_s0", 64'(sc(0)), 64'h0);
            check("bub_v0", 64'(stage_valid[0]), 64'h0);
        end
        check("bub_cnt2", 64'(bubble_cnt), 64'(exp_bub(2)));
        nop_req = 1'b0;

        // Fill 1,2,3 then hold with a flush of stage 1
        for (int i = 1; i <= 3; i++) begin
            id_ctrl = 21'(i);
            tick();
        end
        check("fill_v", 64'(stage_valid), 64'b111);
        check("fill_s2", 64'(sc(2)), 64'h1);
        id_valid = 1'b0;
        id_ctrl  = 21'h0001F;
        hold     = 1'b1;
        flush    = 3'b010;
        tick();
        check("hf_s0", 64'(sc(0)), 64'h3);
        check("hf_s1", 64'(sc(1)), 64'h0);
        check("hf_s2", 64'(sc(2)), 64'h1);
        check("hf_v", 64'(stage_valid), 64'b101);
        flush = 3'b000;
        tick();
        check("hold_v", 64'(stage_valid), 64'b101);
        check("hold_s0", 64'(sc(0)), 64'h3);
        // Advance with stage 2 flushed; invalid entry must not leak its ctrl
        hold  = 1'b0;
        flush = 3'b100;
        tick();
        check("fa_v", 64'(stage_valid), 64'b010);
        check("fa_s1", 64'(sc(1)), 64'h3);
        check("fa_s0_noleak", 64'(sc(0)), 64'h0);
        check("fa_s2", 64'(sc(2)), 64'h0);
        flush = 3'b000;

        // Drain a full pipe while entries keep arriving
        id_valid = 1'b1;
        for (int i = 11; i <= 13; i++) begin
            id_ctrl = 21'(i);
            tick();
        end
        check("dfill_v", 64'(stage_valid), 64'b111);
        drain   = 1'b1;
        id_ctrl = 21'(14);
        tick();
        check("dr1_v", 64'(stage_valid), 64'b111);
        check("dr1_s0", 64'(sc(0)), 64'd14);
        check("dr1_drained", 64'(drained), 64'h0);
        tick();
        check("dr2_v", 64'(stage_valid), 64'b110);
        check("dr2_s0", 64'(sc(0)), 64'h0);
        check("dr2_drained", 64'(drained), 64'h0);
        tick();
        check("dr3_v", 64'(stage_valid), 64'b100);
        check("dr3_s2", 64'(sc(2)), 64'd14);
        check("dr3_drained", 64'(drained), 64'h0);
        tick();
        check("dr4_v", 64'(stage_valid), 64'b000);
        check("dr4_drained", 64'(drained), 64'h1);
        check("dr4_bub", 64'(bubble_cnt), 64'(exp_bub(5)));
        tick();
        check("idle_stay", 64'(drained), 64'h1);
        check("idle_bub", 64'(bubble_cnt), 64'(exp_bub(6)));
        drain    = 1'b0;
        id_valid = 1'b0;
        tick();
        check("idle_run", 64'(drained), 64'h0);
        id_valid = 1'b1;
        id_ctrl  = 21'(15);
        tick();
        check("run_s0", 64'(sc(0)), 64'd15);
        check("run_v", 64'(stage_valid), 64'b001);

        // Reset during DRAIN with two valid stages
        id_ctrl = 21'(16);
        drain   = 1'b1;
        tick();
        check("pre_rst_v", 64'(stage_valid), 64'b011);
        id_valid = 1'b0;
        reset    = 1'b0;
        tick();
        check("mrst_v", 64'(stage_valid), 64'h0);
        check("mrst_ctrl", 64'(stage_ctrl), 64'h0);
        check("mrst_drained", 64'(drained), 64'h0);
        check("mrst_bub", 64'(bubble_cnt), 64'h0);
        reset    = 1'b1;
        drain    = 1'b0;
        id_valid = 1'b1;
        id_ctrl  = 21'(17);
        tick();
        check("mrst_run_s0", 64'(sc(0)), 64'd17);

        // Saturation, then clear beating a same-edge increment
        nop_req = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        check("sat", 64'(bubble_cnt), 64'(PERF ? 16'hFFFF : 16'h0000));
        cnt_clr = 1'b1;
        tick();
        check("clr_wins", 64'(bubble_cnt), 64'h0);
        cnt_clr = 1'b0;
        tick();
        check("after_clr", 64'(bubble_cnt), 64'(exp_bub(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
